// File: rtl/ahblite_timer.sv
// AHB-Lite zero-wait-state timer: 32-bit down counter, 8-bit prescaler,
// periodic/one-shot modes and a level interrupt.
module ahblite_timer #(
    parameter logic [31:0] RESET_LOAD = 32'h0000_0000
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [3:0]  HPROT,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic        TIMER_IRQ
);

    // Address-phase capture
    logic       dp_vld_q;
    logic [1:0] dp_word_q;
    logic [1:0] dp_lane_q;
    logic [1:0] dp_size_q;
    logic       dp_write_q;
    logic       accept;

    // Timer state
    logic        en_q, en_d;
    logic        inten_q, inten_d;
    logic        oneshot_q, oneshot_d;
    logic [7:0]  prescale_q, prescale_d;
    logic [31:0] load_q, load_d;
    logic [31:0] value_q, value_d;
    logic [7:0]  pc_q, pc_d;
    logic        if_q, if_d;

    logic [3:0]  be;
    logic        wr_en, wr_ctrl, wr_load, wr_status;
    logic        tick, tick_eff, if_set;

    logic unused;
    assign unused = ^{HADDR[31:4], HPROT, HSIZE[2]};

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign accept    = HSEL & HTRANS[1] & HREADY;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_vld_q   <= 1'b0;
            dp_word_q  <= 2'd0;
            dp_lane_q  <= 2'd0;
            dp_size_q  <= 2'd0;
            dp_write_q <= 1'b0;
        end else if (HREADY) begin
            dp_vld_q <= accept;
            if (accept) begin
                dp_word_q  <= HADDR[3:2];
                dp_lane_q  <= HADDR[1:0];
                dp_size_q  <= HSIZE[1:0];
                dp_write_q <= HWRITE;
            end
        end
    end

    always_comb begin
        be = 4'b1111;
        case (dp_size_q)
            2'd0:    be = 4'b0001 << dp_lane_q;
            2'd1:    be = dp_lane_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    assign wr_en     = dp_vld_q & dp_write_q & HREADY;
    assign wr_ctrl   = wr_en & (dp_word_q == 2'd0);
    assign wr_load   = wr_en & (dp_word_q == 2'd1);
    assign wr_status = wr_en & (dp_word_q == 2'd3);

    assign tick     = en_q & (pc_q == prescale_q);
    // A LOAD write in the same edge cancels the tick's counter effects entirely
    assign tick_eff = tick & ~wr_load;

    always_comb begin
        en_d       = en_q;
        inten_d    = inten_q;
        oneshot_d  = oneshot_q;
        prescale_d = prescale_q;
        load_d     = load_q;
        value_d    = value_q;
        pc_d       = pc_q;
        if_d       = if_q;
        if_set     = 1'b0;

        if (en_q)
            pc_d = tick ? 8'd0 : pc_q + 8'd1;

        if (tick_eff) begin
            if (value_q == 32'd0) begin
                value_d = load_q;
                if_set  = 1'b1;
                if (oneshot_q)
                    en_d = 1'b0;
            end else begin
                value_d = value_q - 32'd1;
            end
        end

        if (wr_ctrl) begin
            if (be[0]) begin
                en_d      = HWDATA[0];
                inten_d   = HWDATA[1];
                oneshot_d = HWDATA[2];
            end
            if (be[1])
                prescale_d = HWDATA[15:8];
        end

        if (wr_load) begin
            for (int i = 0; i < 4; i++)
                if (be[i])
                    load_d[8*i +: 8] = HWDATA[8*i +: 8];
            value_d = load_d;
            pc_d    = 8'd0;
        end

        if (wr_status && be[0] && HWDATA[0])
            if_d = 1'b0;
        if (if_set)
            if_d = 1'b1;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            en_q       <= 1'b0;
            inten_q    <= 1'b0;
            oneshot_q  <= 1'b0;
            prescale_q <= 8'd0;
            load_q     <= RESET_LOAD;
            value_q    <= RESET_LOAD;
            pc_q       <= 8'd0;
            if_q       <= 1'b0;
        end else begin
            en_q       <= en_d;
            inten_q    <= inten_d;
            oneshot_q  <= oneshot_d;
            prescale_q <= prescale_d;
            load_q     <= load_d;
            value_q    <= value_d;
            pc_q       <= pc_d;
            if_q       <= if_d;
        end
    end

    always_comb begin
        HRDATA = 32'd0;
        if (dp_vld_q) begin
            case (dp_word_q)
                2'd0:    HRDATA = {16'd0, prescale_q, 5'd0, oneshot_q, inten_q, en_q};
                2'd1:    HRDATA = load_q;
                2'd2:    HRDATA = value_q;
                default: HRDATA = {31'd0, if_q};
            endcase
        end
    end

    assign TIMER_IRQ = if_q & inten_q;

endmodule

// File: tb/tb_ahblite_timer.sv
// Scoreboard bench for ahblite_timer: reads push expected data at the address
// phase and are compared when the data phase completes.
module tb_ahblite_timer;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic        TIMER_IRQ;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] sb_q[$];
    string       tag_q[$];

    logic        p_v, p_w;
    logic [31:0] p_d;

    ahblite_timer dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA), .HRESP(HRESP), .TIMER_IRQ(TIMER_IRQ)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    // One bus cycle: completes the previous data phase and issues a new address phase.
    task automatic step(input bit v, input bit w, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] d, input logic [31:0] e, input string tag);
        logic [31:0] exp_v;
        string       exp_t;
        @(negedge HCLK);
        if (p_v && !p_w) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                exp_v = sb_q.pop_front();
                exp_t = tag_q.pop_front();
                chk(exp_t, HRDATA, exp_v);
                chk({exp_t, "_rdy"}, {31'd0, HREADYOUT}, 32'd1);
            end
        end
        HWDATA = (p_v && p_w) ? p_d : 32'd0;
        HSEL   = v;
        HTRANS = v ? 2'b10 : 2'b00;
        HADDR  = a;
        HWRITE = w;
        HSIZE  = sz;
        if (v && !w) begin
            sb_q.push_back(e);
            tag_q.push_back(tag);
        end
        p_v = v;
        p_w = w;
        p_d = d;
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        step(1'b1, 1'b1, a, sz, d, 32'd0, "");
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
        step(1'b1, 1'b0, a, 3'd2, 32'd0, e, tag);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 3'd0, 32'd0, 32'd0, "");
    endtask

    task automatic do_reset(input string tag);
        @(negedge HCLK);
        HRESET = 1'b1;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        p_v    = 1'b0;
        sb_q.delete();
        tag_q.delete();
        #1;
        chk({tag, "_irq"}, {31'd0, TIMER_IRQ}, 32'd0);
        chk({tag, "_rdyout"}, {31'd0, HREADYOUT}, 32'd1);
        chk({tag, "_resp"}, {31'd0, HRESP}, 32'd0);
        @(negedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;
    endtask

    initial begin
        HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = '0; HSIZE = 3'd2;
        HPROT = 4'h3; HWRITE = 1'b0; HWDATA = '0; HREADY = 1'b1;
        p_v = 1'b0; p_w = 1'b0; p_d = '0;
        do_reset("por");

        // Reset values, back-to-back reads
        rd(32'h0, 32'h0, "rst_ctrl");
        rd(32'h4, 32'h0, "rst_load");
        rd(32'h8, 32'h0, "rst_value");
        rd(32'hC, 32'h0, "rst_status");
        idle();

        // Periodic, PRESCALE=0
        wr(32'h4, 3'd2, 32'd3);
        wr(32'h0, 3'd2, 32'h0003);
        rd(32'h8, 32'd3, "per_v3");
        rd(32'h8, 32'd2, "per_v2");
        rd(32'h8, 32'd1, "per_v1");
        rd(32'h8, 32'd0, "per_v0");
        rd(32'h8, 32'd3, "per_reload");
        chk("per_irq_lo", {31'd0, TIMER_IRQ}, 32'd0);
        rd(32'h8, 32'd2, "per_v2b");
        chk("per_irq_hi", {31'd0, TIMER_IRQ}, 32'd1);
        rd(32'h8, 32'd1, "per_v1b");
        rd(32'hC, 32'd1, "per_if");
        idle();

        // Mid-count reset drops IRQ at once and restores VALUE
        do_reset("midrst");
        rd(32'h8, 32'd0, "midrst_value");
        rd(32'h0, 32'd0, "midrst_ctrl");
        idle();

        // Prescaler: PRESCALE=4, LOAD=1
        wr(32'h4, 3'd2, 32'd1);
        wr(32'h0, 3'd2, 32'h0401);
        repeat (4) idle();
        rd(32'h8, 32'd1, "psc_v1");
        rd(32'h8, 32'd0, "psc_v0");
        repeat (3) idle();
        rd(32'hC, 32'd0, "psc_if_lo");
        rd(32'hC, 32'd1, "psc_if_hi");
        idle();
        chk("psc_irq", {31'd0, TIMER_IRQ}, 32'd0);

        // One-shot
        do_reset("os");
        wr(32'h4, 3'd2, 32'd2);
        wr(32'h0, 3'd2, 32'h0007);
        repeat (3) idle();
        rd(32'hC, 32'd1, "os_if");
        rd(32'h0, 32'h0006, "os_ctrl");
        chk("os_irq_hi", {31'd0, TIMER_IRQ}, 32'd1);
        rd(32'h8, 32'd2, "os_value");
        rd(32'h8, 32'd2, "os_hold");
        wr(32'hC, 3'd2, 32'd1);
        rd(32'hC, 32'd0, "os_if_clr");
        idle();
        chk("os_irq_lo", {31'd0, TIMER_IRQ}, 32'd0);

        // Sub-word writes with junk on unselected lanes
        do_reset("sub");
        wr(32'h5, 3'd0, 32'hDEAD_ABEF);
        wr(32'h6, 3'd1, 32'h1234_5678);
        rd(32'h4, 32'h1234_AB00, "sub_load");
        rd(32'h8, 32'h1234_AB00, "sub_value");
        idle();

        // Hardware IF set beats a same-edge W1C (LOAD=0 sets IF on every tick)
        do_reset("col1");
        wr(32'h0, 3'd2, 32'h0001);
        idle();
        wr(32'hC, 3'd2, 32'd1);
        rd(32'hC, 32'd1, "col_if_set_wins");
        idle();

        // LOAD write on a tick edge, then EN cleared on a tick edge
        do_reset("col2");
        wr(32'h4, 3'd2, 32'd5);
        wr(32'h0, 3'd2, 32'h0001);
        wr(32'h4, 3'd2, 32'd9);
        rd(32'h8, 32'd9, "col_load_wins");
        rd(32'h8, 32'd8, "col_after_load");
        wr(32'h0, 3'd2, 32'h0000);
        idle();
        rd(32'h8, 32'd6, "col_en_clr_tick");
        rd(32'h8, 32'd6, "col_en_hold");
        rd(32'hC, 32'd0, "col_no_if");
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ahblite_timer.md
Name: ahblite_timer

Overview:
- AHB-Lite slave that hangs off one peripheral port of the system AHB-Lite interconnect, directly downstream of the address decoder and slave mux.
- Provides a 32-bit down-counting timer with an 8-bit prescaler, periodic and one-shot modes, and a level interrupt to the Cortex-M0.
- Always zero-wait-state and never returns an error response.

Parameters:
- RESET_LOAD, 32'h0000_0000, reset value of the LOAD and VALUE registers.

Ports:
- HCLK       input   1   bus and timer clock
- HRESET     input   1   asynchronous reset, active-high
- HSEL       input   1   slave select from the interconnect decoder
- HADDR      input   32  address; only HADDR[3:0] is used
- HTRANS     input   2   transfer type; HTRANS[1]=1 means NONSEQ or SEQ
- HSIZE      input   3   0=byte, 1=halfword, 2=word
- HPROT      input   4   ignored
- HWRITE     input   1   1=write
- HWDATA     input   32  write data, data phase
- HREADY     input   1   bus-wide HREADY from the interconnect
- HREADYOUT  output  1   constant 1
- HRDATA     output  32  read data, data phase
- HRESP      output  1   constant 0 (OKAY)
- TIMER_IRQ  output  1   interrupt, level, active-high

Behaviour:
- Transfer accepted at a rising edge when HSEL & HTRANS[1] & HREADY. On acceptance, register HADDR[3:2], HADDR[1:0], HSIZE and HWRITE plus a valid flag; the valid flag clears on any HREADY-high edge without acceptance.
- Writes commit at the edge that ends the data phase, i.e. the cycle after acceptance, using HWDATA.
- Byte enables:
  - size 0 → lane HADDR[1:0]
  - size 1 → lanes {HADDR[1],0} and +1
  - size 2 → all lanes
  - Only the enabled lanes are written.
- Reads: HRDATA is a combinational mux on the registered word address while the data-phase valid flag is set; otherwise 0. Whole word returned; the master selects lanes.
- Register map:
  - 0x0 CTRL (rw): [0] EN, [1] INTEN, [2] ONESHOT, [15:8] PRESCALE; all other bits read 0.
  - 0x4 LOAD (rw): a write also copies the new value into VALUE and clears the prescaler count in the same edge.
  - 0x8 VALUE (ro): writes ignored.
  - 0xC STATUS: [0] IF; writing 1 to bit 0 clears IF, writing 0 has no effect.
- Reset values: CTRL=0, LOAD=VALUE=RESET_LOAD, prescaler count=0, IF=0, TIMER_IRQ=0, HRDATA=0, valid flag=0.
- Prescaler: 8-bit count PC advances only while EN=1.
  - If PC==PRESCALE: tick=1, PC←0; otherwise PC←PC+1.
  - Counter therefore ticks every PRESCALE+1 cycles; PRESCALE=0 ticks every cycle.
  - While EN=0: PC holds, no tick.
- Counter, on tick:
  - VALUE≠0 → VALUE←VALUE−1.
  - VALUE==0 → IF←1, VALUE←LOAD; if ONESHOT, EN←0 in the same edge.
  - LOAD=0 gives an IF set on every tick.
- Simultaneous events:
  - IF set by hardware and STATUS write-1-clear in the same edge: set wins.
  - LOAD write and tick in the same edge: LOAD write wins (VALUE←new LOAD, PC←0, no decrement, no IF).
  - CTRL write clearing EN and tick in the same edge: the tick is still processed, then EN=0.
  - ONESHOT clearing EN and a CTRL write in the same edge: the CTRL write value wins.
- TIMER_IRQ = IF & INTEN, combinational from registers.
- HRESET asserted mid-operation: all state returns to reset values immediately (asynchronous); any pending data phase is dropped.
- No wait states: HREADYOUT=1 and HRESP=0 at all times, including during reset.

Test Plan:
- Reset value check: assert HRESET mid-count → TIMER_IRQ=0 immediately. After release, read CTRL=0, LOAD=0, VALUE=0, STATUS=0, each with zero wait states.
- Periodic mode: write LOAD=3, then CTRL=0x0003 (PRESCALE=0) → VALUE reads 3,2,1,0 on successive cycles; IF and TIMER_IRQ rise on the 4th tick; VALUE reloads to 3; period is 4 cycles.
- Prescaler: LOAD=1, CTRL=0x0401 (PRESCALE=4, EN) → VALUE decrements every 5 cycles; IF set 10 cycles after enable; TIMER_IRQ stays 0 because INTEN=0.
- One-shot: LOAD=2, CTRL=0x0007 → after 3 ticks IF=1, EN reads 0, VALUE=2 and holds; writing STATUS=1 → IF=0 and TIMER_IRQ=0.
- Sub-word write: byte write 0xAB to 0x5, then halfword write 0x1234 to 0x6 → LOAD=0x1234AB00 and VALUE=0x1234AB00.
- Collision cases:
  - STATUS write-1-clear on the same edge as a hardware IF set → IF remains 1.
  - LOAD write on a tick edge → VALUE equals the new LOAD, with no decrement.
